// File: rtl/clock_time_setter.sv
// Button-driven time/date editor: debounces mode/inc, walks a field-by-field
// edit session over a shadow copy of the calendar and emits a one-cycle load.
module clock_time_setter #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned BLINK_CYCLES    = 12500000
) (
  input  logic        built_in_clk,
  input  logic        glob_rst_n,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic [5:0]  cur_sec,
  input  logic [5:0]  cur_min,
  input  logic [4:0]  cur_hour,
  input  logic [4:0]  cur_day,
  input  logic [3:0]  cur_mon,
  input  logic [13:0] cur_year,
  output logic [5:0]  set_sec,
  output logic [5:0]  set_min,
  output logic [4:0]  set_hour,
  output logic [4:0]  set_day,
  output logic [3:0]  set_mon,
  output logic [13:0] set_year,
  output logic        load,
  output logic        editing,
  output logic [2:0]  edit_field,
  output logic        blink
);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned BW = $clog2(BLINK_CYCLES + 1);

  typedef enum logic [2:0] {
    S_RUN = 3'd0, S_YEAR = 3'd1, S_MON = 3'd2, S_DAY = 3'd3,
    S_HOUR = 3'd4, S_MIN = 3'd5, S_COMMIT = 3'd6
  } state_t;

  state_t r_state, w_next;

  // bit 0 = mode, bit 1 = inc
  logic [1:0]         r_s1, r_s2, r_db, r_db_q;
  logic [1:0][DW-1:0] r_cnt;
  logic               w_mode_p, w_inc_p, w_in_edit, w_next_edit;
  logic [4:0]         w_dmax;
  logic [5:0]         r_sh_min;
  logic [4:0]         r_sh_hour, r_sh_day;
  logic [3:0]         r_sh_mon;
  logic [13:0]        r_sh_year;
  logic [BW-1:0]      r_blink_cnt;

  function automatic logic [4:0] days_in(input logic [3:0] m, input logic [13:0] y);
    logic leap;
    leap = ((y % 14'd4 == 14'd0) && (y % 14'd100 != 14'd0)) || (y % 14'd400 == 14'd0);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: days_in = 5'd30;
      4'd2:                    days_in = leap ? 5'd29 : 5'd28;
      default:                 days_in = 5'd31;
    endcase
  endfunction

  always_ff @(posedge built_in_clk or negedge glob_rst_n) begin
    if (!glob_rst_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_db   <= '0;
      r_db_q <= '0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= {btn_inc, btn_mode};
      r_s2   <= r_s1;
      r_db_q <= r_db;
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_s2[i] != r_db[i]) begin
          if (r_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            r_db[i]  <= r_s2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Mode has priority: a coincident inc pulse is dropped.
  assign w_mode_p    = r_db[0] & ~r_db_q[0];
  assign w_inc_p     = r_db[1] & ~r_db_q[1] & ~w_mode_p;
  assign w_in_edit   = (r_state inside {S_YEAR, S_MON, S_DAY, S_HOUR, S_MIN});
  assign w_next_edit = (w_next inside {S_YEAR, S_MON, S_DAY, S_HOUR, S_MIN});
  assign w_dmax      = days_in(r_sh_mon, r_sh_year);

  always_ff @(posedge built_in_clk or negedge glob_rst_n) begin
    if (!glob_rst_n) r_state <= S_RUN;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RUN:    if (w_mode_p) w_next = S_YEAR;
      S_YEAR:   if (w_mode_p) w_next = S_MON;
      S_MON:    if (w_mode_p) w_next = S_DAY;
      S_DAY:    if (w_mode_p) w_next = S_HOUR;
      S_HOUR:   if (w_mode_p) w_next = S_MIN;
      S_MIN:    if (w_mode_p) w_next = S_COMMIT;
      S_COMMIT: w_next = S_RUN;
      default:  w_next = S_RUN;
    endcase
  end

  always_ff @(posedge built_in_clk or negedge glob_rst_n) begin
    if (!glob_rst_n) begin
      r_sh_min  <= '0;
      r_sh_hour <= '0;
      r_sh_day  <= 5'd1;
      r_sh_mon  <= 4'd1;
      r_sh_year <= '0;
    end else if (r_state == S_RUN && w_mode_p) begin
      r_sh_min  <= cur_min;
      r_sh_hour <= cur_hour;
      r_sh_day  <= cur_day;
      r_sh_mon  <= cur_mon;
      r_sh_year <= cur_year;
    end else if (w_in_edit && w_inc_p) begin
      case (r_state)
        S_YEAR:  r_sh_year <= (r_sh_year >= 14'd9999) ? 14'd0 : r_sh_year + 14'd1;
        S_MON:   r_sh_mon  <= (r_sh_mon >= 4'd12) ? 4'd1 : r_sh_mon + 4'd1;
        S_DAY:   r_sh_day  <= (r_sh_day >= w_dmax) ? 5'd1 : r_sh_day + 5'd1;
        S_HOUR:  r_sh_hour <= (r_sh_hour >= 5'd23) ? 5'd0 : r_sh_hour + 5'd1;
        S_MIN:   r_sh_min  <= (r_sh_min >= 6'd59) ? 6'd0 : r_sh_min + 6'd1;
        default: ;
      endcase
    end else if (r_sh_day > w_dmax) begin
      r_sh_day <= w_dmax;
    end
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge built_in_clk or negedge glob_rst_n) begin
    if (!glob_rst_n) begin
      load        <= 1'b0;
      editing     <= 1'b0;
      edit_field  <= '0;
      blink       <= 1'b0;
      r_blink_cnt <= '0;
      set_sec     <= '0;
      set_min     <= '0;
      set_hour    <= '0;
      set_day     <= 5'd1;
      set_mon     <= 4'd1;
      set_year    <= '0;
    end else begin
      load       <= (w_next == S_COMMIT);
      editing    <= w_next_edit;
      edit_field <= w_next_edit ? w_next : 3'd0;
      if (w_next == S_COMMIT) begin
        set_sec  <= '0;
        set_min  <= r_sh_min;
        set_hour <= r_sh_hour;
        set_day  <= r_sh_day;
        set_mon  <= r_sh_mon;
        set_year <= r_sh_year;
      end
      if (!w_next_edit || w_next != r_state) begin
        blink       <= 1'b0;
        r_blink_cnt <= '0;
      end else if (r_blink_cnt == BW'(BLINK_CYCLES - 1)) begin
        blink       <= ~blink;
        r_blink_cnt <= '0;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  logic w_unused;
  assign w_unused = ^cur_sec;
endmodule

// File: tb/tb_clock_time_setter.sv
// Self-checking bench for clock_time_setter: vector table of edit sessions plus
// hand-written reset/debounce/priority/blink sequences; commits scored via a queue.
module tb_clock_time_setter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_mode, btn_inc;
  logic [5:0]  cur_sec, cur_min;
  logic [4:0]  cur_hour, cur_day;
  logic [3:0]  cur_mon;
  logic [13:0] cur_year;
  logic [5:0]  set_sec, set_min;
  logic [4:0]  set_hour, set_day;
  logic [3:0]  set_mon;
  logic [13:0] set_year;
  logic        load, editing, blink;
  logic [2:0]  edit_field;

  always #5 clk = ~clk;

  clock_time_setter #(.DEBOUNCE_CYCLES(4), .BLINK_CYCLES(8)) dut (
    .built_in_clk(clk), .glob_rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour), .cur_day(cur_day),
    .cur_mon(cur_mon), .cur_year(cur_year),
    .set_sec(set_sec), .set_min(set_min), .set_hour(set_hour), .set_day(set_day),
    .set_mon(set_mon), .set_year(set_year),
    .load(load), .editing(editing), .edit_field(edit_field), .blink(blink)
  );

  typedef struct { int y; int m; int d; int h; int mi; } exp_t;
  typedef struct { int y; int m; int d; int h; int mi; int f;
                   int ey; int em; int ed; int eh; int emi; } tv_t;

  exp_t q[$];
  tv_t  tv[11];
  int   n_checks = 0;
  int   n_err = 0;
  int   n_loads = 0;
  int   n_exp_loads = 0;

  always @(negedge clk) if (rst_n && load) n_loads++;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic m, input logic i);
    @(posedge clk); #1;
    btn_mode = m; btn_inc = i;
    repeat (10) @(posedge clk);
    #1 btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_cur(input int y, input int m, input int d, input int h, input int mi, input int s);
    cur_year = 14'(y); cur_mon = 4'(m); cur_day = 5'(d);
    cur_hour = 5'(h);  cur_min = 6'(mi); cur_sec = 6'(s);
  endtask

  task automatic expect_commit(input int y, input int m, input int d, input int h, input int mi);
    exp_t e;
    e.y = y; e.m = m; e.d = d; e.h = h; e.mi = mi;
    q.push_back(e);
    n_exp_loads++;
  endtask

  // Final mode press of a session: wait (bounded) for load and score it.
  task automatic commit_press();
    bit   seen;
    exp_t e;
    seen = 1'b0;
    @(posedge clk); #1 btn_mode = 1'b1;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (load) begin
        seen = 1'b1;
        if (q.size() == 0) begin
          chk("commit_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          chk("commit_year", int'(set_year), e.y);
          chk("commit_mon",  int'(set_mon),  e.m);
          chk("commit_day",  int'(set_day),  e.d);
          chk("commit_hour", int'(set_hour), e.h);
          chk("commit_min",  int'(set_min),  e.mi);
          chk("commit_sec",  int'(set_sec),  0);
        end
      end
    end
    if (!seen) chk("load_timeout", 0, 1);
    #1 btn_mode = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("editing_after_commit", int'(editing), 0);
  endtask

  task automatic run_vec(input tv_t v);
    set_cur(v.y, v.m, v.d, v.h, v.mi, 30);
    for (int f = 1; f <= 5; f++) begin
      press(1'b1, 1'b0);
      chk("vec_field", int'(edit_field), f);
      if (f == v.f) press(1'b0, 1'b1);
    end
    expect_commit(v.ey, v.em, v.ed, v.eh, v.emi);
    commit_press();
  endtask

  initial begin
    int   prev, cnt;
    bit   bad;
    exp_t last;

    tv[0]  = '{y:2024, m:1,  d:31, h:10, mi:20, f:2, ey:2024, em:2,  ed:29, eh:10, emi:20};
    tv[1]  = '{y:2100, m:1,  d:31, h:10, mi:20, f:2, ey:2100, em:2,  ed:28, eh:10, emi:20};
    tv[2]  = '{y:1900, m:1,  d:31, h:3,  mi:4,  f:2, ey:1900, em:2,  ed:28, eh:3,  emi:4};
    tv[3]  = '{y:2000, m:1,  d:31, h:3,  mi:4,  f:2, ey:2000, em:2,  ed:29, eh:3,  emi:4};
    tv[4]  = '{y:9999, m:5,  d:10, h:5,  mi:6,  f:1, ey:0,    em:5,  ed:10, eh:5,  emi:6};
    tv[5]  = '{y:2023, m:12, d:15, h:8,  mi:9,  f:2, ey:2023, em:1,  ed:15, eh:8,  emi:9};
    tv[6]  = '{y:2023, m:6,  d:15, h:23, mi:9,  f:4, ey:2023, em:6,  ed:15, eh:0,  emi:9};
    tv[7]  = '{y:2023, m:6,  d:15, h:12, mi:59, f:5, ey:2023, em:6,  ed:15, eh:12, emi:0};
    tv[8]  = '{y:2024, m:2,  d:29, h:1,  mi:2,  f:1, ey:2025, em:2,  ed:28, eh:1,  emi:2};
    tv[9]  = '{y:2023, m:4,  d:30, h:1,  mi:2,  f:3, ey:2023, em:4,  ed:1,  eh:1,  emi:2};
    tv[10] = '{y:2024, m:2,  d:28, h:1,  mi:2,  f:3, ey:2024, em:2,  ed:29, eh:1,  emi:2};

    btn_mode = 1'b0; btn_inc = 1'b0; rst_n = 1'b0;
    set_cur(2022, 7, 14, 6, 33, 12);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_editing", int'(editing), 0);
    chk("rst_field",   int'(edit_field), 0);
    chk("rst_load",    int'(load), 0);
    chk("rst_blink",   int'(blink), 0);
    chk("rst_set_day", int'(set_day), 1);
    chk("rst_set_mon", int'(set_mon), 1);
    chk("rst_set_yr",  int'(set_year), 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Short glitch is filtered.
    @(posedge clk); #1 btn_mode = 1'b1;
    repeat (3) @(posedge clk);
    #1 btn_mode = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("glitch_field", int'(edit_field), 0);
    // Long hold gives exactly one advance.
    @(posedge clk); #1 btn_mode = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("hold_field", int'(edit_field), 1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("hold_no_repeat", int'(edit_field), 1);
    #1 btn_mode = 1'b0;
    repeat (12) @(posedge clk);
    for (int f = 2; f <= 5; f++) press(1'b1, 1'b0);
    expect_commit(2022, 7, 14, 6, 33);
    commit_press();

    // Full edit session.
    set_cur(2023, 1, 31, 10, 59, 45);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    chk("full_field_hour", int'(edit_field), 4);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    expect_commit(2024, 1, 31, 11, 0);
    commit_press();

    // Reset in the middle of EDIT_DAY.
    for (int f = 1; f <= 3; f++) press(1'b1, 1'b0);
    chk("pre_rst_field", int'(edit_field), 3);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midrst_editing", int'(editing), 0);
    chk("midrst_field",   int'(edit_field), 0);
    chk("midrst_load",    int'(load), 0);
    chk("midrst_set_day", int'(set_day), 1);
    chk("midrst_set_mon", int'(set_mon), 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("postrst_editing", int'(editing), 0);

    for (int i = 0; i < 11; i++) run_vec(tv[i]);

    // Coincident mode+inc in EDIT_HOUR: mode wins, hour untouched.
    set_cur(2023, 3, 3, 7, 15, 0);
    for (int f = 1; f <= 4; f++) press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    chk("simul_field", int'(edit_field), 5);
    expect_commit(2023, 3, 3, 7, 15);
    last = q[0];
    commit_press();

    // Inc in RUN changes nothing; blink stays low.
    bad = 1'b0;
    @(posedge clk); #1 btn_inc = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (blink || editing || load) bad = 1'b1;
      if (k == 15) btn_inc = 1'b0;
    end
    chk("run_inc_quiet", int'(bad), 0);
    chk("run_inc_field", int'(edit_field), 0);
    chk("run_inc_hour",  int'(set_hour), last.h);
    chk("run_inc_min",   int'(set_min), last.mi);

    // Blink period while editing.
    press(1'b1, 1'b0);
    chk("blink_field", int'(edit_field), 1);
    prev = int'(blink);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (int'(blink) != prev) break;
    end
    prev = int'(blink);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cnt++;
      if (int'(blink) != prev) break;
    end
    chk("blink_period", cnt, 8);
    for (int f = 2; f <= 5; f++) press(1'b1, 1'b0);
    expect_commit(2023, 3, 3, 7, 15);
    commit_press();
    @(negedge clk);
    chk("blink_after", int'(blink), 0);

    chk("load_count", n_loads, n_exp_loads);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/clock_time_setter.md
Name: clock_time_setter

Overview:
- Button-driven time/date editor: the write side of clock_topmodule's calendar counters.
- Turns two raw push-buttons (mode, inc) into a field-by-field edit session over a shadow copy of the current time and date.
- Ends the session with a single-cycle load pulse carrying the new values into the counter chain.
- Sits next to clock_topmodule on the 50 MHz built_in_clk domain.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles a synchronized button level must stay stable before it is accepted (20 ms at 50 MHz).
- BLINK_CYCLES, 12500000, half-period of the blink output while editing.

Ports:
built_in_clk  input  1  system clock, 50 MHz
glob_rst_n  input  1  reset, asynchronous, active-low
btn_mode  input  1  raw mode button, active-high, asynchronous
btn_inc  input  1  raw increment button, active-high, asynchronous
cur_sec  input  6  current seconds, 0..59
cur_min  input  6  current minutes, 0..59
cur_hour  input  5  current hours, 0..23
cur_day  input  5  current day, 1..31
cur_mon  input  4  current month, 1..12
cur_year  input  14  current year, 0..9999
set_sec  output  6  value to load
set_min  output  6  value to load
set_hour  output  5  value to load
set_day  output  5  value to load
set_mon  output  4  value to load
set_year  output  14  value to load
load  output  1  one-cycle pulse; counters take set_* on this cycle
editing  output  1  high while in any EDIT state
edit_field  output  3  field being edited: 0 none, 1 year, 2 mon, 3 day, 4 hour, 5 min
blink  output  1  display blank toggle for the edited field

Behaviour:
- Reset (async, glob_rst_n=0):
  - state=RUN; load=0, editing=0, edit_field=0, blink=0.
  - set_sec=0, set_min=0, set_hour=0, set_day=1, set_mon=1, set_year=0.
  - Debounce counters and sync flops cleared.
  - Reset mid-edit discards the shadow values; no load is issued.
- Button conditioning, per button:
  - 2-FF synchronizer feeds a stability counter; the debounced level updates after DEBOUNCE_CYCLES consecutive equal samples.
  - A 0->1 edge of the debounced level produces a one-cycle press pulse.
  - Holding a button produces no repeat pulses.
- State machine: RUN -> EDIT_YEAR -> EDIT_MON -> EDIT_DAY -> EDIT_HOUR -> EDIT_MIN -> COMMIT -> RUN. Only a mode pulse advances it, except COMMIT, which exits after 1 cycle.
- RUN + mode pulse: shadow registers take cur_* in that same cycle; next state EDIT_YEAR.
- RUN + inc pulse: ignored.
- EDIT_x + inc pulse: the shadow field increments one cycle later, with wrap:
  - year: 9999 -> 0
  - mon: 12 -> 1
  - day: max -> 1
  - hour: 23 -> 0
  - min: 59 -> 0
- Day maximum:
  - 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11.
  - February: 29 if leap, else 28. Leap means (year%4==0 and year%100!=0) or year%400==0.
- Day clamp: after any year or month increment, if shadow_day > new max, shadow_day = max on the following cycle.
- Mode and inc pulses in the same cycle: mode wins; the inc is dropped.
- COMMIT (exactly 1 cycle):
  - load=1.
  - set_* = shadow values, with set_sec=0.
  - set_* hold until the next COMMIT.
- Output timing:
  - editing and edit_field are registered and reflect the current state.
  - blink resets to 0 on entering any EDIT state and toggles every BLINK_CYCLES while editing; it is 0 in RUN/COMMIT.
- Latency:
  - Raw press to press pulse: 2 + DEBOUNCE_CYCLES cycles.
  - Press pulse to state/shadow change: 1 cycle.
  - Mode pulse in EDIT_MIN to load: 1 cycle.
- Seconds cannot be edited; load always zeroes seconds.

Test Plan (DEBOUNCE_CYCLES=4, BLINK_CYCLES=8):
1. Reset-value check:
   - Stimulus: assert glob_rst_n=0 while in EDIT_DAY.
   - Response: editing=0, edit_field=0, load=0, set_day=1, set_mon=1 immediately. No load pulse after release.
2. Debounce:
   - Stimulus: btn_mode high for 3 cycles, then low.
   - Response: no state change.
   - Stimulus: btn_mode high for 10 cycles.
   - Response: exactly one transition to edit_field=1; no repeat while held.
3. Full edit and commit:
   - Stimulus: cur = 2023-01-31 10:59:45. Sequence mode, inc, mode, mode, mode, inc, mode, inc, mode.
   - Response: a single load pulse with set_year=2024, mon=1, day=31, hour=11, min=0, sec=0; editing=0 afterwards.
4. Day clamp and leap year:
   - Stimulus: cur = 2024-01-31. Mode, mode, inc (month->2).
   - Response: shadow day becomes 29.
   - Stimulus: repeat with year 2100.
   - Response: shadow day becomes 28; 1900 gives 28; 2000 gives 29.
5. Wrap-around:
   - Stimulus: inc on year 9999, mon 12, hour 23, min 59.
   - Response: 0, 1, 0, 0 respectively.
6. Simultaneous and RUN pulses:
   - Stimulus: mode and inc pulses in the same cycle while in EDIT_HOUR.
   - Response: advances to EDIT_MIN with hour unchanged.
   - Stimulus: inc in RUN.
   - Response: no output change.
   - Check: blink toggles every 8 cycles only while editing=1.
